alu_issue_stage: RTL and testbench

- Two-stage issue/writeback wrapper on the initiator side of the ALU interface.
- Accepts RV32I integer instructions with their register operands and decodes them to an ALU opcode plus operands.
- Registers those values into an Execute (E) stage that drives the combinational ALU, then captures the ALU result into a Writeback (W) stage.
- Both stages use valid/ready handshakes and support backpressure.

---
 rtl/alu_issue_stage_pkg.sv | 52 +++++
 rtl/alu_issue_stage_decode.sv | 81 ++++++++
 rtl/alu_issue_stage.sv | 124 ++++++++++++
 tb/tb_alu_issue_stage.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage: ALU select encoding,
// RV32I opcode / funct constants and a funct3 -> base ALU op helper.
package alu_issue_stage_pkg;

    // Select encoding consumed by the downstream ALU.
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_COPY1 = 4'd10
    } alu_sel_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLT     = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_XOR     = 3'd4;
    localparam logic [2:0] F3_SRL_SRA = 3'd5;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ALU op for a funct3 when funct7 carries no alternate selection.
    function automatic alu_sel_e base_sel(input logic [2:0] f3);
        case (f3)
            F3_ADD_SUB: return ALU_ADD;
            F3_SLL:     return ALU_SLL;
            F3_SLT:     return ALU_SLT;
            F3_SLTU:    return ALU_SLTU;
            F3_XOR:     return ALU_XOR;
            F3_SRL_SRA: return ALU_SRL;
            F3_OR:      return ALU_OR;
            F3_AND:     return ALU_AND;
            default:    return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_stage_decode.sv
// rv32_alu_decode: combinational RV32I -> ALU operand/select decode.
// Illegal encodings become COPY1 of zero so they retire with a zero result.
module rv32_alu_decode
    import alu_issue_stage_pkg::*;
(
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output alu_sel_e    sel,
    output logic [4:0]  rd,
    output logic        illegal
);

    logic [6:0]  opcode;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] shamt;

    assign opcode = inst[6:0];
    assign f7     = inst[31:25];
    assign f3     = inst[14:12];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_u  = {inst[31:12], 12'b0};
    assign shamt  = {27'b0, inst[24:20]};

    // Decode opcode/funct fields into operands and ALU select.
    always_comb begin
        op1     = '0;
        op2     = '0;
        sel     = ALU_COPY1;
        illegal = 1'b0;
        rd      = inst[11:7];
        case (opcode)
            OPC_OP: begin
                op1 = rs1;
                op2 = rs2;
                if (f7 == F7_BASE)                         sel = base_sel(f3);
                else if (f7 == F7_ALT && f3 == F3_ADD_SUB) sel = ALU_SUB;
                else if (f7 == F7_ALT && f3 == F3_SRL_SRA) sel = ALU_SRA;
                else                                       illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                op1 = rs1;
                op2 = imm_i;
                if (f3 == F3_SLL) begin
                    op2 = shamt;
                    if (f7 == F7_BASE) sel = ALU_SLL;
                    else               illegal = 1'b1;
                end else if (f3 == F3_SRL_SRA) begin
                    op2 = shamt;
                    if (f7 == F7_BASE)     sel = ALU_SRL;
                    else if (f7 == F7_ALT) sel = ALU_SRA;
                    else                   illegal = 1'b1;
                end else begin
                    sel = base_sel(f3);
                end
            end
            OPC_LUI: begin
                sel = ALU_COPY1;
                op1 = imm_u;
            end
            OPC_AUIPC: begin
                sel = ALU_ADD;
                op1 = pc;
                op2 = imm_u;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            sel = ALU_COPY1;
            op1 = '0;
            op2 = '0;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: E/W two-stage issue wrapper around an external
// combinational ALU, valid/ready on both sides.
// Optional macro ALU_ISSUE_BYPASS_EN: forward in-flight E/W results into
// rs1/rs2 at decode.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    output logic [XLEN-1:0] alu_op1,
    output logic [XLEN-1:0] alu_op2,
    output logic [3:0]      alu_sel,
    input  logic [XLEN-1:0] alu_out,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_illegal
);

    logic            e_valid;
    logic [4:0]      e_rd;
    logic            e_illegal;
    logic            w_load;
    logic            accept;
    logic [XLEN-1:0] dec_rs1;
    logic [XLEN-1:0] dec_rs2;
    logic [XLEN-1:0] dec_op1;
    logic [XLEN-1:0] dec_op2;
    alu_sel_e        dec_sel;
    logic [4:0]      dec_rd;
    logic            dec_illegal;

    assign w_load   = e_valid && (!wb_valid || wb_ready);
    assign in_ready = !e_valid || w_load;
    assign accept   = in_valid && in_ready;

`ifdef ALU_ISSUE_BYPASS_EN
    logic [4:0] rs1_idx;
    logic [4:0] rs2_idx;
    assign rs1_idx = in_inst[19:15];
    assign rs2_idx = in_inst[24:20];

    // rs1 source: E result first (if legal), then W result, then the input.
    always_comb begin
        dec_rs1 = in_rs1_val;
        if (rs1_idx != 5'd0 && e_valid && !e_illegal && rs1_idx == e_rd)
            dec_rs1 = alu_out;
        else if (rs1_idx != 5'd0 && wb_valid && rs1_idx == wb_rd)
            dec_rs1 = wb_data;
    end

    // rs2 source, same priority as rs1.
    always_comb begin
        dec_rs2 = in_rs2_val;
        if (rs2_idx != 5'd0 && e_valid && !e_illegal && rs2_idx == e_rd)
            dec_rs2 = alu_out;
        else if (rs2_idx != 5'd0 && wb_valid && rs2_idx == wb_rd)
            dec_rs2 = wb_data;
    end
`else
    assign dec_rs1 = in_rs1_val;
    assign dec_rs2 = in_rs2_val;
`endif

    rv32_alu_decode u_decode (
        .inst    (in_inst),
        .pc      (in_pc),
        .rs1     (dec_rs1),
        .rs2     (dec_rs2),
        .op1     (dec_op1),
        .op2     (dec_op2),
        .sel     (dec_sel),
        .rd      (dec_rd),
        .illegal (dec_illegal)
    );

    // E stage: capture decoded instruction on accept, drain on move to W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_valid   <= 1'b0;
            alu_op1   <= '0;
            alu_op2   <= '0;
            alu_sel   <= ALU_ADD;
            e_rd      <= '0;
            e_illegal <= 1'b0;
        end else if (accept) begin
            e_valid   <= 1'b1;
            alu_op1   <= dec_op1;
            alu_op2   <= dec_op2;
            alu_sel   <= dec_sel;
            e_rd      <= dec_rd;
            e_illegal <= dec_illegal;
        end else if (w_load) begin
            e_valid   <= 1'b0;
        end
    end

    // W stage: capture ALU result, hold until the consumer takes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            wb_illegal <= 1'b0;
        end else if (w_load) begin
            wb_valid   <= 1'b1;
            wb_rd      <= e_rd;
            wb_data    <= e_illegal ? '0 : alu_out;
            wb_illegal <= e_illegal;
        end else if (wb_ready) begin
            wb_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios with literal
// expectations plus randomized traffic against a result-level model.
module tb_alu_issue_stage;
    import alu_issue_stage_pkg::*;

    typedef struct packed {
        logic        ill;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

`ifdef ALU_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [3:0]  alu_sel;
    logic [31:0] alu_out;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_illegal;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    exp_t m_e, m_w;
    bit   m_e_v = 1'b0;
    bit   m_w_v = 1'b0;

    exp_t logq[$];
    int   logc[$];

    alu_issue_stage #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .in_pc      (in_pc),
        .in_rs1_val (in_rs1_val),
        .in_rs2_val (in_rs2_val),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_sel    (alu_sel),
        .alu_out    (alu_out),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .wb_illegal (wb_illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External ALU attached to the DUT.
    always_comb begin
        case (alu_sel)
            ALU_ADD:   alu_out = alu_op1 + alu_op2;
            ALU_SUB:   alu_out = alu_op1 - alu_op2;
            ALU_AND:   alu_out = alu_op1 & alu_op2;
            ALU_OR:    alu_out = alu_op1 | alu_op2;
            ALU_XOR:   alu_out = alu_op1 ^ alu_op2;
            ALU_SLT:   alu_out = {31'b0, $signed(alu_op1) < $signed(alu_op2)};
            ALU_SLTU:  alu_out = {31'b0, alu_op1 < alu_op2};
            ALU_SLL:   alu_out = alu_op1 << alu_op2[4:0];
            ALU_SRL:   alu_out = alu_op1 >> alu_op2[4:0];
            ALU_SRA:   alu_out = $signed(alu_op1) >>> alu_op2[4:0];
            ALU_COPY1: alu_out = alu_op1;
            default:   alu_out = 32'd0;
        endcase
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Architectural result of one RV32I instruction given its source values.
    function automatic exp_t ref_exec(input logic [31:0] inst, pc, a, b);
        exp_t r;
        logic [31:0] imm, u;
        logic [4:0]  sh;
        logic [6:0]  f7;
        logic [2:0]  f3;
        imm = {{20{inst[31]}}, inst[31:20]};
        u   = {inst[31:12], 12'b0};
        sh  = inst[24:20];
        f7  = inst[31:25];
        f3  = inst[14:12];
        r.ill  = 1'b0;
        r.rd   = inst[11:7];
        r.data = 32'd0;
        case (inst[6:0])
            7'h33: case ({f7, f3})
                {7'h00, 3'd0}: r.data = a + b;
                {7'h20, 3'd0}: r.data = a - b;
                {7'h00, 3'd1}: r.data = a << b[4:0];
                {7'h00, 3'd2}: r.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                {7'h00, 3'd3}: r.data = (a < b) ? 32'd1 : 32'd0;
                {7'h00, 3'd4}: r.data = a ^ b;
                {7'h00, 3'd5}: r.data = a >> b[4:0];
                {7'h20, 3'd5}: r.data = $signed(a) >>> b[4:0];
                {7'h00, 3'd6}: r.data = a | b;
                {7'h00, 3'd7}: r.data = a & b;
                default:       r.ill = 1'b1;
            endcase
            7'h13: case (f3)
                3'd0: r.data = a + imm;
                3'd2: r.data = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
                3'd3: r.data = (a < imm) ? 32'd1 : 32'd0;
                3'd4: r.data = a ^ imm;
                3'd6: r.data = a | imm;
                3'd7: r.data = a & imm;
                3'd1: if (f7 == 7'h00) r.data = a << sh; else r.ill = 1'b1;
                default: begin
                    if (f7 == 7'h00)      r.data = a >> sh;
                    else if (f7 == 7'h20) r.data = $signed(a) >>> sh;
                    else                  r.ill = 1'b1;
                end
            endcase
            7'h37: r.data = u;
            7'h17: r.data = pc + u;
            default: r.ill = 1'b1;
        endcase
        if (r.ill) r.data = 32'd0;
        return r;
    endfunction

    // Value an instruction actually sees for source register rs.
    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] v);
        if (BYP && rs != 5'd0 && m_e_v && !m_e.ill && m_e.rd == rs) return m_e.data;
        if (BYP && rs != 5'd0 && m_w_v && m_w.rd == rs) return m_w.data;
        return v;
    endfunction

    function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'h13};
    endfunction

    // Model: two slots holding finished results, moving by the handshake rules.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_e_v <= 1'b0;
            m_w_v <= 1'b0;
        end else begin
            bit   wl, rdy;
            exp_t nx;
            wl  = m_e_v && (!m_w_v || wb_ready);
            rdy = !m_e_v || wl;
            nx  = ref_exec(in_inst, in_pc, fwd(in_inst[19:15], in_rs1_val),
                           fwd(in_inst[24:20], in_rs2_val));
            if (wl) begin
                m_w   <= m_e;
                m_w_v <= 1'b1;
            end else if (wb_ready) begin
                m_w_v <= 1'b0;
            end
            if (in_valid && rdy) begin
                m_e   <= nx;
                m_e_v <= 1'b1;
            end else if (wl) begin
                m_e_v <= 1'b0;
            end
        end
    end

    // Compare DUT against the model every cycle, mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            check("in_ready", {31'b0, in_ready},
                  {31'b0, (!m_e_v || !m_w_v || wb_ready)});
            check("wb_valid", {31'b0, wb_valid}, {31'b0, m_w_v});
            if (m_w_v && wb_valid) begin
                check("wb_rd", {27'b0, wb_rd}, {27'b0, m_w.rd});
                check("wb_data", wb_data, m_w.data);
                check("wb_illegal", {31'b0, wb_illegal}, {31'b0, m_w.ill});
            end
        end
    end

    // Record every retired result as seen on the W port.
    always @(negedge clk) begin
        if (rst && wb_valid && wb_ready) begin
            logq.push_back('{ill: wb_illegal, rd: wb_rd, data: wb_data});
            logc.push_back(cyc);
        end
    end

    task automatic send(input logic [31:0] inst, pc, a, b);
        bit done;
        done       = 1'b0;
        in_inst    = inst;
        in_pc      = pc;
        in_rs1_val = a;
        in_rs2_val = b;
        in_valid   = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: in_ready never high for inst 0x%08h", inst);
        end
    endtask

    task automatic wait_retired(input int n);
        for (int i = 0; i < 50 && logq.size() < n; i++) begin
            @(negedge clk);
            #1;
        end
        check("retired_count", logq.size(), n);
    endtask

    function automatic logic [31:0] log_data(input int i);
        if (i < logq.size()) return logq[i].data;
        return 32'hDEAD_BEEF;
    endfunction

    initial begin
        exp_t r;
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_inst    = 32'd0;
        in_pc      = 32'd0;
        in_rs1_val = 32'd0;
        in_rs2_val = 32'd0;
        wb_ready   = 1'b1;

        #2;
        check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        check("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_illegal", {31'b0, wb_illegal}, 32'd0);
        check("rst_alu_op1", alu_op1, 32'd0);
        check("rst_alu_op2", alu_op2, 32'd0);
        check("rst_alu_sel", {28'b0, alu_sel}, {28'b0, ALU_ADD});
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'b0, in_ready}, 32'd1);

        // Pin the reference model with hand-computed results.
        r = ref_exec(r_ins(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'd0, 32'd5, 32'd7);
        check("pin_add", r.data, 32'd12);
        r = ref_exec(r_ins(7'h20, 5'd2, 5'd1, 3'd0, 5'd6), 32'd0, 32'd3, 32'd5);
        check("pin_sub", r.data, 32'hFFFF_FFFE);
        r = ref_exec(i_ins(12'h404, 5'd1, 3'd5, 5'd4), 32'd0, 32'h8000_0000, 32'd0);
        check("pin_srai", r.data, 32'hF800_0000);
        r = ref_exec(32'h0000_007F, 32'd0, 32'd1, 32'd1);
        check("pin_illegal", {31'b0, r.ill}, 32'd1);

        // ADD x3,x1,x2 and its 2-cycle latency.
        @(posedge clk); #1;
        send(r_ins(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'h100, 32'd5, 32'd7);
        @(negedge clk);
        check("lat_e_stage", {31'b0, wb_valid}, 32'd0);
        @(negedge clk);
        check("lat_w_valid", {31'b0, wb_valid}, 32'd1);
        check("add_rd", {27'b0, wb_rd}, 32'd3);
        check("add_data", wb_data, 32'd12);
        check("add_illegal", {31'b0, wb_illegal}, 32'd0);

        // Back-to-back SUB, SRAI, LUI at full throughput.
        repeat (2) @(negedge clk);
        logq.delete(); logc.delete();
        @(posedge clk); #1;
        send(r_ins(7'h20, 5'd2, 5'd1, 3'd0, 5'd6), 32'h0, 32'd3, 32'd5);
        send(i_ins(12'h404, 5'd1, 3'd5, 5'd4), 32'h0, 32'h8000_0000, 32'd0);
        send({20'h12345, 5'd5, 7'h37}, 32'h0, 32'd0, 32'd0);
        wait_retired(3);
        check("b2b_sub", log_data(0), 32'hFFFF_FFFE);
        check("b2b_srai", log_data(1), 32'hF800_0000);
        check("b2b_lui", log_data(2), 32'h1234_5000);
        if (logc.size() == 3) begin
            check("b2b_gap1", logc[1] - logc[0], 32'd1);
            check("b2b_gap2", logc[2] - logc[1], 32'd1);
        end

        // Backpressure: two buffered, third stalls until wb_ready returns.
        logq.delete(); logc.delete();
        @(posedge clk); #1;
        wb_ready = 1'b0;
        send(r_ins(7'h00, 5'd2, 5'd1, 3'd0, 5'd7), 32'h0, 32'd5, 32'd7);
        send(r_ins(7'h00, 5'd2, 5'd1, 3'd4, 5'd8), 32'h0, 32'h0000_00F0, 32'h0000_000F);
        in_inst    = r_ins(7'h00, 5'd2, 5'd1, 3'd6, 5'd9);
        in_rs1_val = 32'h0000_00A0;
        in_rs2_val = 32'h0000_0005;
        in_valid   = 1'b1;
        @(negedge clk);
        check("bp_stall1", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        check("bp_stall2", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        wb_ready = 1'b1;
        send(r_ins(7'h00, 5'd2, 5'd1, 3'd6, 5'd9), 32'h0, 32'h0000_00A0, 32'h0000_0005);
        wait_retired(3);
        repeat (4) @(negedge clk);
        check("bp_no_dup", logq.size(), 32'd3);
        check("bp_first", log_data(0), 32'd12);
        check("bp_second", log_data(1), 32'h0000_00FF);
        check("bp_third", log_data(2), 32'h0000_00A5);

        // Illegal instruction followed by a normal ADD.
        logq.delete(); logc.delete();
        @(posedge clk); #1;
        send(32'h0000_007F, 32'h0, 32'h1234, 32'h5678);
        @(negedge clk);
        check("ill_alu_sel", {28'b0, alu_sel}, {28'b0, ALU_COPY1});
        check("ill_alu_op1", alu_op1, 32'd0);
        @(posedge clk); #1;
        send(r_ins(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'h0, 32'd5, 32'd7);
        wait_retired(2);
        if (logq.size() >= 2) begin
            check("ill_flag", {31'b0, logq[0].ill}, 32'd1);
            check("ill_data", logq[0].data, 32'd0);
            check("ill_rd", {27'b0, logq[0].rd}, 32'd0);
            check("post_ill_flag", {31'b0, logq[1].ill}, 32'd0);
            check("post_ill_data", logq[1].data, 32'd12);
        end

        // Asynchronous reset with both stages full.
        @(posedge clk); #1;
        wb_ready = 1'b0;
        send(r_ins(7'h00, 5'd2, 5'd1, 3'd0, 5'd10), 32'h0, 32'd1, 32'd1);
        send(r_ins(7'h00, 5'd2, 5'd1, 3'd0, 5'd11), 32'h0, 32'd2, 32'd2);
        #2;
        check("pre_rst_full", {31'b0, wb_valid}, 32'd1);
        rst = 1'b0;
        #1;
        check("async_rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        check("async_rst_wb_data", wb_data, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        logq.delete(); logc.delete();
        wb_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("no_stale_result", logq.size(), 32'd0);

        // ADDI x1,x0,9 then ADD x2,x1,x1 with zero register inputs.
        logq.delete(); logc.delete();
        @(posedge clk); #1;
        send(i_ins(12'd9, 5'd0, 3'd0, 5'd1), 32'h0, 32'd0, 32'd0);
        send(r_ins(7'h00, 5'd1, 5'd1, 3'd0, 5'd2), 32'h0, 32'd0, 32'd0);
        wait_retired(2);
        check("bypass_addi", log_data(0), 32'd9);
        check("bypass_add", log_data(1), BYP ? 32'd18 : 32'd0);

        // Randomized traffic; the per-cycle compare does the checking.
        for (int i = 0; i < 600; i++) begin
            int k, s;
            logic [6:0] f7;
            @(posedge clk); #1;
            in_valid = ($urandom_range(0, 3) != 0);
            wb_ready = ($urandom_range(0, 3) != 0);
            k = $urandom_range(0, 9);
            s = $urandom_range(0, 9);
            f7 = (s < 6) ? 7'h00 : (s < 9) ? 7'h20 : 7'($urandom);
            in_inst = $urandom;
            in_inst[11:7]  = 5'($urandom_range(0, 3));
            in_inst[19:15] = 5'($urandom_range(0, 3));
            in_inst[24:20] = 5'($urandom_range(0, 3));
            if (k < 4) begin
                in_inst[6:0]   = 7'h33;
                in_inst[31:25] = f7;
            end else if (k < 7) begin
                in_inst[6:0] = 7'h13;
                if (in_inst[14:12] == 3'd1 || in_inst[14:12] == 3'd5)
                    in_inst[31:25] = f7;
            end else if (k == 7) begin
                in_inst[6:0] = 7'h37;
            end else if (k == 8) begin
                in_inst[6:0] = 7'h17;
            end
            in_pc      = $urandom;
            in_rs1_val = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
            in_rs2_val = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wb_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("drained", {31'b0, wb_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
